// File: rtl/symbol_streamer.sv
// symbol_streamer: accepts addressed UART byte packets, packs the bytes into
// little-endian words in a FIFO and drains it as evenly spaced modulator symbols.

typedef struct packed {
  logic       Valid;
  logic       SoP;
  logic       EoP;
  logic [7:0] Destination;
  logic [7:0] Data;
} UART_PACKET;

module symbol_streamer #(
  parameter logic [7:0] DEST_ADDR     = 8'h10,
  parameter int         WORD_BYTES    = 2,
  parameter int         SYMBOL_BITS   = 4,
  parameter int         FIFO_DEPTH    = 4096,
  parameter int         SYMBOL_PERIOD = 1046025,
  parameter bit         MSB_FIRST     = 1'b0
) (
  input  logic                        ipClk,
  input  logic                        ipReset,
  input  UART_PACKET                  ipRxStream,
  input  logic                        ipEnable,
  input  logic                        ipClearFlags,
  output logic [$clog2(FIFO_DEPTH):0] opFIFO_Size,
  output logic                        opOverflow,
  output logic                        opUnderrun,
  output logic [SYMBOL_BITS-1:0]      opSymbol,
  output logic                        opSymbolValid,
  output logic [8*WORD_BYTES-1:0]     opWord,
  output logic                        opWordValid
);

  localparam int W    = 8 * WORD_BYTES;
  localparam int NSYM = W / SYMBOL_BITS;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int IW   = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int TW   = $clog2(SYMBOL_PERIOD);

  typedef enum logic [1:0] {
    WR_WAIT    = 2'd0,
    WR_COLLECT = 2'd1,
    WR_DROP    = 2'd2
  } wr_state_t;

  wr_state_t        wr_state_q, wr_state_d, eff_state_s, byte_next_s;
  logic [LW-1:0]    lane_q, lane_d, byte_lane_s;
  logic [W-1:0]     buf_q, buf_d;
  logic             push_pend_q, push_pend_d;
  logic [W-1:0]     push_word_q, push_word_d;
  logic             push_s, pop_s, ovf_set_s, und_set_s, take_s, addr_hit_s;
  logic             fifo_full_s;

  logic [W-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;

  logic             hold_valid_q, hold_valid_d;
  logic [W-1:0]     hold_word_q, hold_word_d;
  logic [IW-1:0]    sym_idx_q, sym_idx_d, sel_s;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             tick_s, last_s;
  logic [SYMBOL_BITS-1:0] slice_s;

  logic [SYMBOL_BITS-1:0] sym_q, sym_d;
  logic             symv_q, symv_d;
  logic [W-1:0]     word_q, word_d;
  logic             wordv_q, wordv_d;
  logic             ovf_q, ovf_d, und_q, und_d;

  assign fifo_full_s = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop_s       = !hold_valid_q && (count_q != (AW+1)'(0));
  assign tick_s      = ipEnable && (tmr_q == TW'(SYMBOL_PERIOD - 1));
  assign last_s      = (sym_idx_q == IW'(NSYM - 1));
  assign sel_s       = MSB_FIRST ? (IW'(NSYM - 1) - sym_idx_q) : sym_idx_q;
  assign slice_s     = hold_word_q[int'(sel_s)*SYMBOL_BITS +: SYMBOL_BITS];

  // Write side: packet framing, byte-lane packing and push/overflow decision.
  always_comb begin
    lane_d      = lane_q;
    buf_d       = buf_q;
    push_pend_d = 1'b0;
    push_word_d = push_word_q;
    push_s      = 1'b0;
    ovf_set_s   = 1'b0;
    take_s      = 1'b0;
    byte_lane_s = lane_q;
    eff_state_s = wr_state_q;
    byte_next_s = wr_state_q;
    addr_hit_s  = ipRxStream.SoP && (ipRxStream.Destination == DEST_ADDR);

    // A word that finds the FIFO full is lost, and the rest of its packet with it.
    if (push_pend_q && fifo_full_s) begin
      ovf_set_s = 1'b1;
      if (wr_state_q == WR_COLLECT) begin
        eff_state_s = WR_DROP;
      end else begin
        eff_state_s = wr_state_q;
      end
    end else begin
      push_s = push_pend_q;
    end

    case (eff_state_s)
      WR_WAIT: begin
        take_s      = addr_hit_s;
        byte_lane_s = LW'(0);
        byte_next_s = addr_hit_s ? WR_COLLECT : WR_WAIT;
      end
      WR_COLLECT: begin
        if (ipRxStream.SoP) begin
          take_s      = addr_hit_s;
          byte_lane_s = LW'(0);
          byte_next_s = addr_hit_s ? WR_COLLECT : WR_WAIT;
        end else begin
          take_s      = 1'b1;
          byte_lane_s = lane_q;
          byte_next_s = WR_COLLECT;
        end
      end
      WR_DROP: begin
        take_s      = 1'b0;
        byte_next_s = WR_DROP;
      end
      default: begin
        take_s      = 1'b0;
        byte_next_s = WR_WAIT;
      end
    endcase

    if (ipRxStream.Valid) begin
      wr_state_d = ipRxStream.EoP ? WR_WAIT : byte_next_s;
      if (take_s) begin
        buf_d[int'(byte_lane_s)*8 +: 8] = ipRxStream.Data;
        if (byte_lane_s == LW'(WORD_BYTES - 1)) begin
          push_pend_d = 1'b1;
          push_word_d = buf_d;
          lane_d      = LW'(0);
        end else begin
          lane_d      = byte_lane_s + LW'(1);
        end
      end else begin
        lane_d = lane_q;
      end
    end else begin
      wr_state_d = eff_state_s;
    end
  end

  // FIFO occupancy bookkeeping.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Read side: holding register refill, symbol timer and symbol slicing.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_word_d  = hold_word_q;
    sym_idx_d    = sym_idx_q;
    sym_d        = sym_q;
    symv_d       = 1'b0;
    word_d       = word_q;
    wordv_d      = 1'b0;
    und_set_s    = tick_s && !hold_valid_q;

    if (ipEnable) begin
      tmr_d = tick_s ? TW'(0) : (tmr_q + TW'(1));
    end else begin
      tmr_d = tmr_q;
    end

    if (pop_s) begin
      hold_valid_d = 1'b1;
      hold_word_d  = mem_q[rd_ptr_q];
      sym_idx_d    = IW'(0);
    end else if (tick_s && hold_valid_q) begin
      sym_d  = slice_s;
      symv_d = 1'b1;
      if (last_s) begin
        word_d       = hold_word_q;
        wordv_d      = 1'b1;
        hold_valid_d = 1'b0;
        sym_idx_d    = IW'(0);
      end else begin
        sym_idx_d    = sym_idx_q + IW'(1);
      end
    end else begin
      hold_valid_d = hold_valid_q;
    end

    // Setting a sticky flag beats clearing it in the same cycle.
    ovf_d = ovf_set_s ? 1'b1 : (ipClearFlags ? 1'b0 : ovf_q);
    und_d = und_set_s ? 1'b1 : (ipClearFlags ? 1'b0 : und_q);
  end

  // FIFO storage; emptied by pointer reset, so the array itself is not cleared.
  always_ff @(posedge ipClk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_word_q;
    end
  end

  // State and output registers.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      wr_state_q   <= WR_WAIT;
      lane_q       <= LW'(0);
      buf_q        <= W'(0);
      push_pend_q  <= 1'b0;
      push_word_q  <= W'(0);
      wr_ptr_q     <= AW'(0);
      rd_ptr_q     <= AW'(0);
      count_q      <= (AW+1)'(0);
      hold_valid_q <= 1'b0;
      hold_word_q  <= W'(0);
      sym_idx_q    <= IW'(0);
      tmr_q        <= TW'(0);
      sym_q        <= SYMBOL_BITS'(0);
      symv_q       <= 1'b0;
      word_q       <= W'(0);
      wordv_q      <= 1'b0;
      ovf_q        <= 1'b0;
      und_q        <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      lane_q       <= lane_d;
      buf_q        <= buf_d;
      push_pend_q  <= push_pend_d;
      push_word_q  <= push_word_d;
      wr_ptr_q     <= push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_q     <= pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      count_q      <= count_d;
      hold_valid_q <= hold_valid_d;
      hold_word_q  <= hold_word_d;
      sym_idx_q    <= sym_idx_d;
      tmr_q        <= tmr_d;
      sym_q        <= sym_d;
      symv_q       <= symv_d;
      word_q       <= word_d;
      wordv_q      <= wordv_d;
      ovf_q        <= ovf_d;
      und_q        <= und_d;
    end
  end

  assign opFIFO_Size   = count_q;
  assign opOverflow    = ovf_q;
  assign opUnderrun    = und_q;
  assign opSymbol      = sym_q;
  assign opSymbolValid = symv_q;
  assign opWord        = word_q;
  assign opWordValid   = wordv_q;

endmodule

// File: tb/tb_symbol_streamer.sv
// Bench for symbol_streamer: two instances (LSB-first and MSB-first) share one
// stimulus stream and are checked each cycle against a queue-based model.

module tb_symbol_streamer;

  localparam int P = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, clr;
  logic [18:0] rx;

  logic [2:0]  size0, size1;
  logic        ovf0, ovf1, und0, und1, symv0, symv1, wordv0, wordv1;
  logic [3:0]  sym0, sym1;
  logic [15:0] word0, word1;

  symbol_streamer #(.DEST_ADDR(8'h10), .WORD_BYTES(2), .SYMBOL_BITS(4),
                    .FIFO_DEPTH(4), .SYMBOL_PERIOD(P), .MSB_FIRST(1'b0)) dut0 (
    .ipClk(clk), .ipReset(rst), .ipRxStream(rx), .ipEnable(en), .ipClearFlags(clr),
    .opFIFO_Size(size0), .opOverflow(ovf0), .opUnderrun(und0), .opSymbol(sym0),
    .opSymbolValid(symv0), .opWord(word0), .opWordValid(wordv0));

  symbol_streamer #(.DEST_ADDR(8'h10), .WORD_BYTES(2), .SYMBOL_BITS(4),
                    .FIFO_DEPTH(4), .SYMBOL_PERIOD(P), .MSB_FIRST(1'b1)) dut1 (
    .ipClk(clk), .ipReset(rst), .ipRxStream(rx), .ipEnable(en), .ipClearFlags(clr),
    .opFIFO_Size(size1), .opOverflow(ovf1), .opUnderrun(und1), .opSymbol(sym1),
    .opSymbolValid(symv1), .opWord(word1), .opWordValid(wordv1));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  // model state: framing mode 0=wait 1=collect 2=drop
  int          m_mode;
  logic [7:0]  m_bytes[$];
  bit          m_pend;
  logic [15:0] m_pend_w;
  logic [15:0] m_fifo[$];
  bit          m_held;
  logic [15:0] m_hw;
  int          m_nsent;
  int          m_tmr;
  logic [3:0]  m_sym0, m_sym1;
  bit          m_symv, m_wordv, m_ovf, m_und;
  logic [15:0] m_word;

  logic [3:0]  log0[$];
  logic [3:0]  log1[$];
  int          logt[$];
  logic [15:0] wlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    bit tick, full, popnow, ovf_ev, und_ev;
    int mode;
    if (rst) begin
      m_mode = 0; m_bytes.delete(); m_pend = 1'b0; m_pend_w = 16'h0;
      m_fifo.delete(); m_held = 1'b0; m_hw = 16'h0; m_nsent = 0; m_tmr = 0;
      m_sym0 = 4'h0; m_sym1 = 4'h0; m_symv = 1'b0; m_wordv = 1'b0;
      m_word = 16'h0; m_ovf = 1'b0; m_und = 1'b0;
      return;
    end
    tick   = en && (m_tmr == P - 1);
    full   = (m_fifo.size() == 4);
    popnow = !m_held && (m_fifo.size() > 0);
    ovf_ev = 1'b0;
    und_ev = 1'b0;
    m_symv = 1'b0;
    m_wordv = 1'b0;
    if (tick) begin
      if (m_held) begin
        m_sym0 = 4'(m_hw >> (4 * m_nsent));
        m_sym1 = 4'(m_hw >> (4 * (3 - m_nsent)));
        m_symv = 1'b1;
        m_nsent++;
        if (m_nsent == 4) begin
          m_word = m_hw; m_wordv = 1'b1; m_held = 1'b0; m_nsent = 0;
        end
      end else begin
        und_ev = 1'b1;
      end
    end
    if (popnow) begin
      m_hw = m_fifo.pop_front(); m_held = 1'b1; m_nsent = 0;
    end
    mode = m_mode;
    if (m_pend) begin
      if (full) begin
        ovf_ev = 1'b1;
        if (mode == 1) begin mode = 2; m_bytes.delete(); end
      end else begin
        m_fifo.push_back(m_pend_w);
      end
    end
    m_pend = 1'b0;
    if (rx[18]) begin
      if (mode == 0) begin
        if (rx[17] && rx[15:8] == 8'h10) begin
          m_bytes.delete(); m_bytes.push_back(rx[7:0]); mode = 1;
        end
      end else if (mode == 1) begin
        if (rx[17]) begin
          m_bytes.delete();
          if (rx[15:8] == 8'h10) m_bytes.push_back(rx[7:0]);
          else mode = 0;
        end else begin
          m_bytes.push_back(rx[7:0]);
        end
      end
      if (m_bytes.size() == 2) begin
        m_pend = 1'b1; m_pend_w = {m_bytes[1], m_bytes[0]}; m_bytes.delete();
      end
      if (rx[16]) begin mode = 0; m_bytes.delete(); end
    end
    m_mode = mode;
    if (en) m_tmr = tick ? 0 : m_tmr + 1;
    m_ovf = ovf_ev ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_und = und_ev ? 1'b1 : (clr ? 1'b0 : m_und);
  endtask

  // per-cycle comparison against the model, plus strobe logging
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("size0", size0, m_fifo.size());
      chk("size1", size1, m_fifo.size());
      chk("ovf0", ovf0, m_ovf);
      chk("ovf1", ovf1, m_ovf);
      chk("und0", und0, m_und);
      chk("und1", und1, m_und);
      chk("symv0", symv0, m_symv);
      chk("symv1", symv1, m_symv);
      chk("sym0", sym0, m_sym0);
      chk("sym1", sym1, m_sym1);
      chk("wordv0", wordv0, m_wordv);
      chk("wordv1", wordv1, m_wordv);
      if (m_wordv) begin
        chk("word0", word0, m_word);
        chk("word1", word1, m_word);
      end
    end
    if (symv0 === 1'b1) begin log0.push_back(sym0); logt.push_back(cyc); end
    if (symv1 === 1'b1) log1.push_back(sym1);
    if (wordv0 === 1'b1) wlog.push_back(word0);
  end

  task automatic next();
    @(posedge clk);
    cyc++;
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next();
  endtask

  task automatic send(input bit sop, input bit eop, input logic [7:0] dest, input logic [7:0] data);
    rx = {1'b1, sop, eop, dest, data};
    next();
    rx = 19'h0;
  endtask

  task automatic clear_logs();
    log0.delete(); log1.delete(); logt.delete(); wlog.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; rx = 19'h0;
    idle(2);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic chk_seq(input string tag, input int which,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    logic [3:0] e[4];
    int n;
    e[0] = a; e[1] = b; e[2] = c; e[3] = d;
    n = (which == 0) ? log0.size() : log1.size();
    chk({tag, "_count"}, n, 4);
    if (n >= 4) begin
      for (int k = 0; k < 4; k++) chk(tag, (which == 0) ? log0[k] : log1[k], e[k]);
    end
  endtask

  task automatic chk_timing(input string tag, input int t0, input int first_off);
    if (logt.size() >= 4) begin
      chk({tag, "_first"}, logt[0] - t0, first_off);
      for (int k = 1; k < 4; k++) chk({tag, "_gap"}, logt[k] - logt[k-1], P);
    end else begin
      chk({tag, "_strobes"}, logt.size(), 4);
    end
  endtask

  task automatic chk_word(input string tag, input logic [15:0] w);
    chk({tag, "_wcount"}, wlog.size(), 1);
    if (wlog.size() >= 1) chk(tag, wlog[0], w);
  endtask

  initial begin
    int t0;
    rst = 1'b1; en = 1'b0; clr = 1'b0; rx = 19'h0;
    idle(2);
    chk_on = 1'b1;
    do_reset();
    chk("reset_size", size0, 3'd0);
    chk("reset_sym", sym0, 4'h0);

    // 1/2: one word, both symbol orders
    send(1'b1, 1'b0, 8'h10, 8'h34);
    send(1'b0, 1'b1, 8'h10, 8'h12);
    next();
    chk("t1_size_push", size0, 3'd1);
    next();
    chk("t1_size_pop", size0, 3'd0);
    en = 1'b1; t0 = cyc;
    idle(34);
    en = 1'b0;
    chk_seq("t1_lsb", 0, 4'h4, 4'h3, 4'h2, 4'h1);
    chk_seq("t2_msb", 1, 4'h1, 4'h2, 4'h3, 4'h4);
    chk_timing("t1", t0, 8);
    chk_word("t1_word", 16'h1234);
    chk("t1_no_underrun", und0, 1'b0);

    // 3: wrong destination ignored, trailing odd byte discarded
    do_reset();
    send(1'b1, 1'b0, 8'h11, 8'hAA);
    send(1'b0, 1'b1, 8'h11, 8'hBB);
    idle(2);
    chk("t3_foreign", size0, 3'd0);
    send(1'b1, 1'b0, 8'h10, 8'h01);
    send(1'b0, 1'b0, 8'h10, 8'h02);
    send(1'b0, 1'b1, 8'h10, 8'h03);
    chk("t3_one_word", size0, 3'd1);
    en = 1'b1; t0 = cyc;
    idle(34);
    en = 1'b0;
    chk_seq("t3_lsb", 0, 4'h1, 4'h0, 4'h2, 4'h0);
    chk_seq("t3_msb", 1, 4'h0, 4'h2, 4'h0, 4'h1);
    chk_word("t3_word", 16'h0201);

    // 4: overflow mid-packet, rest of packet dropped, recovery after one pop
    do_reset();
    for (int i = 0; i < 14; i++) send(i == 0, i == 13, 8'h10, 8'(i));
    chk("t4_full", size0, 3'd4);
    chk("t4_ovf", ovf0, 1'b1);
    en = 1'b1;
    idle(32);
    en = 1'b0;
    chk_word("t4_word", 16'h0100);
    send(1'b1, 1'b0, 8'h10, 8'hAA);
    send(1'b0, 1'b1, 8'h10, 8'hBB);
    next();
    chk("t4_accept", size0, 3'd4);
    chk("t4_ovf_sticky", ovf0, 1'b1);
    clr = 1'b1;
    next();
    clr = 1'b0;
    chk("t4_ovf_clear", ovf0, 1'b0);

    // 5: underrun on first tick, set beats clear, later word keeps 8-clock grid
    do_reset();
    en = 1'b1; t0 = cyc;
    idle(7);
    chk("t5_pre_tick", und0, 1'b0);
    clr = 1'b1;
    next();
    clr = 1'b0;
    chk("t5_underrun", und0, 1'b1);
    chk("t5_no_strobe", symv0, 1'b0);
    clr = 1'b1;
    next();
    clr = 1'b0;
    chk("t5_und_clear", und0, 1'b0);
    send(1'b1, 1'b0, 8'h10, 8'h78);
    send(1'b0, 1'b1, 8'h10, 8'h56);
    idle(31);
    chk_seq("t5_lsb", 0, 4'h8, 4'h7, 4'h6, 4'h5);
    chk_seq("t5_msb", 1, 4'h5, 4'h6, 4'h7, 4'h8);
    chk_timing("t5", t0, 16);

    // 6: reset mid-packet and mid-word, then a clean restart
    do_reset();
    en = 1'b1;
    send(1'b1, 1'b0, 8'h10, 8'h11);
    send(1'b0, 1'b0, 8'h10, 8'h22);
    send(1'b0, 1'b0, 8'h10, 8'h33);
    idle(2);
    rst = 1'b1;
    next();
    rst = 1'b0;
    chk("t6_size", size0, 3'd0);
    chk("t6_sym", {sym0, sym1}, 8'h00);
    chk("t6_strobes", {symv0, symv1, wordv0, wordv1}, 4'h0);
    chk("t6_flags", {ovf0, ovf1, und0, und1}, 4'h0);
    chk("t6_word", {word0, word1}, 32'h0);
    clear_logs();
    t0 = cyc;
    send(1'b0, 1'b0, 8'h10, 8'hEE);
    send(1'b1, 1'b0, 8'h10, 8'h9A);
    send(1'b0, 1'b1, 8'h10, 8'hBC);
    idle(31);
    chk_seq("t6_lsb", 0, 4'hA, 4'h9, 4'hC, 4'hB);
    chk_seq("t6_msb", 1, 4'hB, 4'hC, 4'h9, 4'hA);
    chk_timing("t6", t0, 8);
    chk_word("t6_wordout", 16'hBC9A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
